// File: rtl/decode_pkg.sv
// Shared decode-stage constants and types for the register file slice.
package decode_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int IMM_W    = 16;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/register_file_if.sv
// Decode/write-back bus into the register file; outputs are the ID/EX operands.
interface register_file_if
  import decode_pkg::*;
#(
  parameter int DW = decode_pkg::DATA_W,
  parameter int AW = decode_pkg::ADDR_W,
  parameter int IW = decode_pkg::IMM_W
);
  logic          stall_flag;
  logic [AW-1:0] read_reg_addr1;
  logic [AW-1:0] read_reg_addr2;
  logic [AW-1:0] reg_wr_addr;
  logic [DW-1:0] reg_wr_data;
  logic          reg_write;
  logic [IW-1:0] inst_imm_field;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic [DW-1:0] sgn_ext_imm;

  modport master (
    output stall_flag, read_reg_addr1, read_reg_addr2,
           reg_wr_addr, reg_wr_data, reg_write, inst_imm_field,
    input  rd_data1, rd_data2, sgn_ext_imm
  );

  modport slave (
    input  stall_flag, read_reg_addr1, read_reg_addr2,
           reg_wr_addr, reg_wr_data, reg_write, inst_imm_field,
    output rd_data1, rd_data2, sgn_ext_imm
  );
endinterface

// File: rtl/sign_extend.sv
// Registered immediate sign-extension; holds its output while stalled.
module sign_extend
  import decode_pkg::*;
#(
  parameter int DW = decode_pkg::DATA_W,
  parameter int IW = decode_pkg::IMM_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_flag,
  input  logic [IW-1:0] inst_imm_field,
  output logic [DW-1:0] sgn_ext_imm
);
  always_ff @(posedge clk) begin
    if (reset)
      sgn_ext_imm <= '0;
    else if (!stall_flag)
      sgn_ext_imm <= {{(DW-IW){inst_imm_field[IW-1]}}, inst_imm_field};
  end
endmodule

// File: rtl/register_file.sv
// 2R1W register file with r0 hardwired to zero, write-through bypass and
// registered (stallable) read operands plus sign-extended immediate.
module register_file
  import decode_pkg::*;
#(
  parameter int DW = decode_pkg::DATA_W,
  parameter int AW = decode_pkg::ADDR_W,
  parameter int IW = decode_pkg::IMM_W
) (
  input logic              clk,
  input logic              reset,
  register_file_if.slave   bus
);
  localparam int NREGS  = 2**AW;
  localparam int NPORTS = 2;

  logic [DW-1:0] mem [NREGS];
  logic          wr_en;
  logic [NPORTS-1:0][AW-1:0] rd_addr;
  logic [NPORTS-1:0][DW-1:0] rd_q;

  assign wr_en   = bus.reg_write && (bus.reg_wr_addr != '0);
  assign rd_addr = {bus.read_reg_addr2, bus.read_reg_addr1};

  // Write-back is never gated by stall; reset discards a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[bus.reg_wr_addr] <= bus.reg_wr_data;
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    logic [DW-1:0] nxt;
    logic [DW-1:0] q;

    always_comb begin
      nxt = mem[rd_addr[p]];
      if (rd_addr[p] == '0)
        nxt = '0;
      else if (wr_en && (bus.reg_wr_addr == rd_addr[p]))
        nxt = bus.reg_wr_data;
    end

    always_ff @(posedge clk) begin
      if (reset)
        q <= '0;
      else if (!bus.stall_flag)
        q <= nxt;
    end

    assign rd_q[p] = q;
  end

  assign bus.rd_data1 = rd_q[0];
  assign bus.rd_data2 = rd_q[1];

  sign_extend #(.DW(DW), .IW(IW)) u_sext (
    .clk            (clk),
    .reset          (reset),
    .stall_flag     (bus.stall_flag),
    .inst_imm_field (bus.inst_imm_field),
    .sgn_ext_imm    (bus.sgn_ext_imm)
  );
endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench: driver queues hand-computed operands per edge,
// a negedge monitor pops and compares them against the registered outputs.
module tb_register_file;
  logic clk = 1'b0;
  logic reset;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ei;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string name, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%08h required=%08h", name, fld, act, req);
    end
  endtask

  // Monitor: outputs are registered, so they are stable by the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.name, "rd_data1",    bus.rd_data1,    e.e1);
        cmp(e.name, "rd_data2",    bus.rd_data2,    e.e2);
        cmp(e.name, "sgn_ext_imm", bus.sgn_ext_imm, e.ei);
      end
    end
  end

  task automatic step(input logic rst, input logic st,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [15:0] imm, input string name,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] ei);
    exp_t e;
    reset              = rst;
    bus.stall_flag     = st;
    bus.read_reg_addr1 = a1;
    bus.read_reg_addr2 = a2;
    bus.reg_write      = we;
    bus.reg_wr_addr    = wa;
    bus.reg_wr_data    = wd;
    bus.inst_imm_field = imm;
    @(posedge clk);
    e.name = name; e.e1 = e1; e.e2 = e2; e.ei = ei;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    //   rst st  a1  a2  we wa  wd            imm       name          e1            e2            ei
    step(1, 0, 0,  0,  0, 0,  32'h0,        16'h0,    "reset",      32'h0,        32'h0,        32'h0);
    for (int i = 0; i < 32; i++)
      step(0, 0, 5'(i), 5'(31 - i), 0, 0, 32'h0, 16'h0, "rst_rd", 32'h0, 32'h0, 32'h0);
    step(0, 0, 0,  0,  1, 9,  32'h77,       16'h0,    "wr_r9",      32'h0,        32'h0,        32'h0);
    step(0, 0, 9,  9,  0, 0,  32'h0,        16'h0,    "rd_r9",      32'h77,       32'h77,       32'h0);
    step(1, 1, 9,  9,  1, 9,  32'h55,       16'hFFFF, "rst_wr",     32'h0,        32'h0,        32'h0);
    step(0, 0, 9,  0,  0, 0,  32'h0,        16'h0,    "rd_r9_rst",  32'h0,        32'h0,        32'h0);
    step(0, 0, 0,  0,  1, 5,  32'hDEADBEEF, 16'h0,    "wr_r5",      32'h0,        32'h0,        32'h0);
    step(0, 0, 5,  5,  0, 0,  32'h0,        16'h0,    "rd_r5",      32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    step(0, 0, 0,  5,  1, 0,  32'h1234,     16'h0,    "wr_r0",      32'h0,        32'hDEADBEEF, 32'h0);
    step(0, 0, 0,  0,  0, 0,  32'h0,        16'h0,    "rd_r0",      32'h0,        32'h0,        32'h0);
    step(0, 0, 7,  0,  1, 7,  32'h11,       16'h0,    "wr_r7",      32'h11,       32'h0,        32'h0);
    step(0, 0, 5,  7,  1, 7,  32'hA5A5A5A5, 16'h0,    "bypass",     32'hDEADBEEF, 32'hA5A5A5A5, 32'h0);
    step(0, 0, 7,  7,  0, 0,  32'h0,        16'h0,    "rd_r7",      32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0);
    step(0, 0, 0,  0,  1, 3,  32'h33,       16'h0,    "wr_r3",      32'h0,        32'h0,        32'h0);
    step(0, 0, 3,  5,  0, 0,  32'h0,        16'h0,    "cap_r3",     32'h33,       32'hDEADBEEF, 32'h0);
    step(0, 1, 4,  7,  1, 3,  32'h99,       16'h1234, "stall",      32'h33,       32'hDEADBEEF, 32'h0);
    step(0, 0, 3,  4,  0, 0,  32'h0,        16'h0,    "post_stall", 32'h99,       32'h0,        32'h0);
    step(0, 0, 0,  0,  0, 0,  32'h0,        16'h7FFF, "sx_pos",     32'h0,        32'h0,        32'h00007FFF);
    step(0, 0, 0,  0,  0, 0,  32'h0,        16'h8000, "sx_min",     32'h0,        32'h0,        32'hFFFF8000);
    step(0, 1, 3,  3,  0, 0,  32'h0,        16'hFFFF, "sx_hold",    32'h0,        32'h0,        32'hFFFF8000);
    step(0, 0, 3,  0,  0, 0,  32'h0,        16'hFFFF, "sx_neg1",    32'h99,       32'h0,        32'hFFFFFFFF);
    step(0, 0, 0,  0,  0, 0,  32'h0,        16'h0,    "sx_zero",    32'h0,        32'h0,        32'h0);

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

Decode-stage storage block: a 32 x 32-bit general-purpose register file with two read ports and one write port, plus a 16-to-32-bit sign-extension unit for the instruction immediate field. Read results and the extended immediate are captured into output registers at the clock edge, so they act as the ID/EX pipeline operands. The write port is driven by the write-back stage. A pipeline stall freezes the captured outputs but never blocks write-back.

## Interface
Parameters:
- DATA_W, 32, register and immediate-output width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- IMM_W, 16, instruction immediate width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- stall_flag  in  1  1 = hold all output registers
- read_reg_addr1  in  ADDR_W  read port 1 address (rs)
- read_reg_addr2  in  ADDR_W  read port 2 address (rt)
- reg_wr_addr  in  ADDR_W  write-back destination address
- reg_wr_data  in  DATA_W  write-back data
- reg_write  in  1  write enable from write-back stage
- inst_imm_field  in  IMM_W  raw immediate from instruction
- rd_data1  out  DATA_W  registered read data, port 1
- rd_data2  out  DATA_W  registered read data, port 2
- sgn_ext_imm  out  DATA_W  registered sign-extended immediate

## Operation
- Register 0 is hardwired to zero. Writes to address 0 are ignored, and reads of address 0 return 0.
- Write: at a rising edge with reg_write=1 and reg_wr_addr!=0, mem[reg_wr_addr] <= reg_wr_data. The write is independent of stall_flag.
- Read capture: at a rising edge with stall_flag=0, rd_dataN <= value of mem[read_reg_addrN].
  - Write-through bypass: if reg_write=1, reg_wr_addr!=0 and reg_wr_addr==read_reg_addrN in the same cycle, rd_dataN captures reg_wr_data instead of the stored value.
  - Both ports may address the same register; each port gets the same value.
- Sign extension: at a rising edge with stall_flag=0, sgn_ext_imm <= {(DATA_W-IMM_W){inst_imm_field[IMM_W-1]}, inst_imm_field}.
- Stall: with stall_flag=1, rd_data1, rd_data2 and sgn_ext_imm hold their previous values. Register writes still complete.
- No internal state machine. The register file is plain storage; there is no scoreboard.

## Timing
- Reset (synchronous, highest priority):
  - At a rising edge with reset=1, all 32 registers become 0, and rd_data1, rd_data2 and sgn_ext_imm become 0.
  - reg_write and stall_flag are ignored in that cycle.
- Reset asserted mid-operation discards any write in that cycle. The next non-reset edge behaves normally.
- Read latency: 1 cycle from address to rd_dataN. Sign-extend latency: 1 cycle from inst_imm_field to sgn_ext_imm.
- Write latency: a value written at edge N is readable at edge N via the bypass, and at any later edge from storage.
- Simultaneous write and read of the same register always returns the new data.
- Outputs change only on rising clk edges. There are no combinational input-to-output paths.

## Structure
- Shared package (decode_pkg):
  - constants DATA_W=32, ADDR_W=5, IMM_W=16, NUM_REGS=32, ZERO_REG=5'd0
  - typedefs reg_addr_t and word_t
- One sub-module, sign_extend: ports clk, reset, stall_flag, inst_imm_field, sgn_ext_imm, holding the registered immediate.
- The register array, read capture and bypass logic live in register_file itself.

## Test plan
- Reset: drive reset=1 for one edge, then read addresses 0..31 over successive cycles -> every rd_data1/rd_data2 = 0 and sgn_ext_imm = 0.
- Write then read: write 0xDEADBEEF to r5. On a later cycle, read_reg_addr1=5 and read_reg_addr2=5 -> both outputs = 0xDEADBEEF one edge later. Write 0x1234 to r0, then read r0 -> 0.
- Bypass: in one cycle, reg_write=1, reg_wr_addr=7, reg_wr_data=0xA5A5A5A5, read_reg_addr2=7 (r7 previously 0x11) -> rd_data2 = 0xA5A5A5A5 after that edge.
- Stall: capture r3=0x33 on rd_data1, then stall_flag=1 while changing read_reg_addr1 to 4 and writing r3=0x99 -> rd_data1 stays 0x33. After stall_flag returns to 0 and addr1 is set back to 3 -> rd_data1 = 0x99.
- Sign extension: inst_imm_field=0x7FFF -> sgn_ext_imm=0x00007FFF. 0x8000 -> 0xFFFF8000. 0xFFFF -> 0xFFFFFFFF. Each value appears one edge later, and is held while stall_flag=1.
- Reset during write: reset=1 and reg_write=1 to r9 with 0x55 in the same cycle -> r9 reads 0 afterwards.
